layered_pixel_gen: RTL and testbench

//  Pipelined, parametrised VGA pixel compositor; sits between the VGA controller and the VGA port.

---
 rtl/pixel_gen_pkg.sv | 23 ++
 rtl/hex_font_rom.sv | 44 ++++
 rtl/layered_pixel_gen.sv | 218 +++++++++++++++++++++
 tb/tb_layered_pixel_gen.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_gen_pkg.sv
// Shared constants for the layered VGA pixel compositor: colours, the
// transparency key, pipeline depth and the debug digit-code width.
package pixel_gen_pkg;

    localparam int PIPE_LATENCY = 2;
    localparam int DIGIT_W      = 4;

    localparam logic [11:0] COLOR_BLACK     = 12'h000;
    localparam logic [11:0] COLOR_WHITE     = 12'hFFF;
    localparam logic [11:0] TRANSPARENT_KEY = 12'hF0F;

    typedef enum logic [1:0] {
        LAYER_TEXT,
        LAYER_CHAR,
        LAYER_MAP,
        LAYER_BG
    } layer_e;

    function automatic logic is_key(input logic [11:0] colour);
        return colour == TRANSPARENT_KEY;
    endfunction

endpackage

// File: rtl/hex_font_rom.sv
// Combinational 16-glyph hex font. (code, row, col) -> pixel bit. Glyphs are
// drawn on an 8x8 grid and scaled to FONT_WIDTH; col 0 is the leftmost pixel.
module hex_font_rom #(
    parameter int FONT_WIDTH = 8,
    parameter int ROW_W      = 3
) (
    input  logic [3:0]       code,
    input  logic [ROW_W-1:0] row,
    input  logic [ROW_W-1:0] col,
    output logic             pixel
);

    logic [63:0] glyph;
    logic [2:0]  r8;
    logic [2:0]  c8;

    always_comb begin
        glyph = '0;
        case (code)
            4'h0: glyph = 64'h3C666E7666663C00;
            4'h1: glyph = 64'h1838181818187E00;
            4'h2: glyph = 64'h3C66060C30607E00;
            4'h3: glyph = 64'h3C66061C06663C00;
            4'h4: glyph = 64'h0C1C3C6C7E0C0C00;
            4'h5: glyph = 64'h7E607C0606663C00;
            4'h6: glyph = 64'h3C607C6666663C00;
            4'h7: glyph = 64'h7E060C1830303000;
            4'h8: glyph = 64'h3C66663C66663C00;
            4'h9: glyph = 64'h3C66663E060C3800;
            4'hA: glyph = 64'h183C66667E666600;
            4'hB: glyph = 64'h7C66667C66667C00;
            4'hC: glyph = 64'h3C66606060663C00;
            4'hD: glyph = 64'h786C6666666C7800;
            4'hE: glyph = 64'h7E60607C60607E00;
            4'hF: glyph = 64'h7E60607C60606000;
            default: glyph = '0;
        endcase
        r8 = 3'((int'(row) * 8) / FONT_WIDTH);
        c8 = 3'((int'(col) * 8) / FONT_WIDTH);
        // Row 0 sits in the top byte and column 0 in its MSB.
        pixel = glyph[{~r8, ~c8}];
    end

endmodule

// File: rtl/layered_pixel_gen.sv
// Two-stage VGA pixel compositor: hex debug text, sprite, map, white background.
// Define CHAR_TRANSPARENCY_EN to make sprite pixels equal to 12'hF0F transparent.
module layered_pixel_gen
    import pixel_gen_pkg::*;
#(
    parameter int SEQ_NUM       = 34,
    parameter int SEQ_DIGITS    = 4,
    parameter int FONT_WIDTH    = 8,
    parameter int SEQ_INTERVAL  = 3,
    parameter int PIXEL_WIDTH   = 12,
    parameter int SCREEN_WIDTH  = 10,
    parameter int MAP_X_OFFSET  = 270,
    parameter int MAP_Y_OFFSET  = 50,
    parameter int MAP_WIDTH_X   = 100,
    parameter int MAP_WIDTH_Y   = 100,
    parameter int CHAR_WIDTH_X  = 32,
    parameter int CHAR_WIDTH_Y  = 32,
    parameter logic [PIXEL_WIDTH-1:0] TEXT_FG = 12'h000,
    parameter logic [PIXEL_WIDTH-1:0] TEXT_BG = 12'hFFF
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst_n,
    input  logic                                  video_on,
    input  logic                                  hsync_in,
    input  logic                                  vsync_in,
    input  logic [SCREEN_WIDTH-1:0]               x,
    input  logic [SCREEN_WIDTH-1:0]               y,
    input  logic [SCREEN_WIDTH-1:0]               char_x,
    input  logic [SCREEN_WIDTH-1:0]               char_y,
    input  logic [SEQ_NUM*SEQ_DIGITS*DIGIT_W-1:0] seq_digits,
    output logic [SCREEN_WIDTH-1:0]               map_x,
    output logic [SCREEN_WIDTH-1:0]               map_y,
    output logic [SCREEN_WIDTH-1:0]               char_x_rom,
    output logic [SCREEN_WIDTH-1:0]               char_y_rom,
    output logic                                  map_on,
    output logic                                  char_on,
    input  logic [PIXEL_WIDTH-1:0]                map_rgb,
    input  logic [PIXEL_WIDTH-1:0]                char_rgb,
    output logic [PIXEL_WIDTH-1:0]                rgb,
    output logic                                  hsync_out,
    output logic                                  vsync_out,
    output logic                                  frame_start
);

    localparam int SW      = SCREEN_WIDTH;
    localparam int FW_LOG2 = $clog2(FONT_WIDTH);
    localparam int FROW_W  = (FW_LOG2 > 0) ? FW_LOG2 : 1;
    localparam int ROW_H   = FONT_WIDTH + SEQ_INTERVAL;
    localparam int LINE_W  = $clog2(ROW_H + 1);
    localparam int IDX_W   = $clog2(SEQ_NUM + 1);
    localparam int DIG_W   = (SEQ_DIGITS > 1) ? $clog2(SEQ_DIGITS) : 1;
    localparam int TEXT_W  = SEQ_DIGITS * FONT_WIDTH;

    localparam logic [SW:0] MAP_X0 = (SW+1)'(MAP_X_OFFSET);
    localparam logic [SW:0] MAP_X1 = (SW+1)'(MAP_X_OFFSET + MAP_WIDTH_X);
    localparam logic [SW:0] MAP_Y0 = (SW+1)'(MAP_Y_OFFSET);
    localparam logic [SW:0] MAP_Y1 = (SW+1)'(MAP_Y_OFFSET + MAP_WIDTH_Y);

    typedef logic [SEQ_NUM-1:0][SEQ_DIGITS-1:0][DIGIT_W-1:0] digit_tab_t;

    // Stage 0: input decode and row tracking state
    logic [SW-1:0]     x_prev;
    logic              line_start;
    logic              frame_start_c;
    digit_tab_t        shadow;
    digit_tab_t        digits_in;
    logic [IDX_W-1:0]  row_idx, row_idx_nx;
    logic [LINE_W-1:0] row_line, row_line_nx;
    logic [IDX_W-1:0]  row_sel;
    logic [DIG_W-1:0]  digit_sel;
    logic              text_hit_c;
    logic [3:0]        code_c;
    logic              map_hit_c;
    logic              char_hit_c;
    logic [SW:0]       x_e, y_e, cx_e, cy_e;

    // Stage 1 registers
    logic              text_hit1;
    logic [3:0]        code1;
    logic [FROW_W-1:0] frow1;
    logic [FROW_W-1:0] fcol1;
    logic              von1;
    logic [PIPE_LATENCY-1:0] hs_pipe;
    logic [PIPE_LATENCY-1:0] vs_pipe;

    // Stage 2
    logic              font_bit;
    logic              char_opaque;
    layer_e            layer;
    logic [PIXEL_WIDTH-1:0] rgb_nx;

    assign digits_in     = seq_digits;
    assign line_start    = (x == '0) && (x_prev != '0);
    assign frame_start_c = line_start && (y == '0);

    // Next-state counters double as the row position of the pixel now at the
    // input, so the first pixel of each line already sees its own row.
    always_comb begin
        row_idx_nx  = row_idx;
        row_line_nx = row_line;
        if (frame_start_c) begin
            row_idx_nx  = '0;
            row_line_nx = '0;
        end else if (line_start) begin
            if (row_line == LINE_W'(ROW_H - 1)) begin
                row_line_nx = '0;
                if (row_idx != IDX_W'(SEQ_NUM))
                    row_idx_nx = row_idx + 1'b1;
            end else begin
                row_line_nx = row_line + 1'b1;
            end
        end
    end

    always_comb begin
        text_hit_c = (row_idx_nx < IDX_W'(SEQ_NUM)) &&
                     (row_line_nx < LINE_W'(FONT_WIDTH)) &&
                     (int'(x) < TEXT_W);
        row_sel    = text_hit_c ? row_idx_nx : '0;
        digit_sel  = text_hit_c ? DIG_W'(x >> FW_LOG2) : '0;
        // A frame start is always row 0, and reads the live inputs being shadowed.
        code_c     = frame_start_c ? digits_in[0][digit_sel] : shadow[row_sel][digit_sel];
    end

    assign x_e  = {1'b0, x};
    assign y_e  = {1'b0, y};
    assign cx_e = {1'b0, char_x};
    assign cy_e = {1'b0, char_y};

    assign map_hit_c  = (x_e >= MAP_X0) && (x_e < MAP_X1) &&
                        (y_e >= MAP_Y0) && (y_e < MAP_Y1);
    assign char_hit_c = (x_e >= cx_e) && (x_e < cx_e + (SW+1)'(CHAR_WIDTH_X)) &&
                        (y_e >= cy_e) && (y_e < cy_e + (SW+1)'(CHAR_WIDTH_Y));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            x_prev      <= '0;
            row_idx     <= IDX_W'(SEQ_NUM);
            row_line    <= '0;
            shadow      <= '0;
            frame_start <= 1'b0;
            map_on      <= 1'b0;
            char_on     <= 1'b0;
            map_x       <= '0;
            map_y       <= '0;
            char_x_rom  <= '0;
            char_y_rom  <= '0;
            text_hit1   <= 1'b0;
            code1       <= '0;
            frow1       <= '0;
            fcol1       <= '0;
            von1        <= 1'b0;
            hs_pipe     <= '0;
            vs_pipe     <= '0;
            rgb         <= '0;
        end else begin
            x_prev      <= x;
            row_idx     <= row_idx_nx;
            row_line    <= row_line_nx;
            frame_start <= frame_start_c;
            if (frame_start_c)
                shadow <= digits_in;
            map_on      <= map_hit_c;
            char_on     <= char_hit_c;
            map_x       <= x - SW'(MAP_X_OFFSET);
            map_y       <= y - SW'(MAP_Y_OFFSET);
            char_x_rom  <= x - char_x;
            char_y_rom  <= y - char_y;
            text_hit1   <= text_hit_c;
            code1       <= code_c;
            frow1       <= row_line_nx[FROW_W-1:0];
            fcol1       <= x[FROW_W-1:0];
            von1        <= video_on;
            hs_pipe     <= {hs_pipe[PIPE_LATENCY-2:0], hsync_in};
            vs_pipe     <= {vs_pipe[PIPE_LATENCY-2:0], vsync_in};
            rgb         <= rgb_nx;
        end
    end

    assign hsync_out = hs_pipe[PIPE_LATENCY-1];
    assign vsync_out = vs_pipe[PIPE_LATENCY-1];

    hex_font_rom #(
        .FONT_WIDTH (FONT_WIDTH),
        .ROW_W      (FROW_W)
    ) u_font (
        .code  (code1),
        .row   (frow1),
        .col   (fcol1),
        .pixel (font_bit)
    );

`ifdef CHAR_TRANSPARENCY_EN
    assign char_opaque = !is_key(12'(char_rgb));
`else
    assign char_opaque = 1'b1;
`endif

    always_comb begin
        layer = LAYER_BG;
        if (text_hit1)
            layer = LAYER_TEXT;
        else if (char_on && char_opaque)
            layer = LAYER_CHAR;
        else if (map_on)
            layer = LAYER_MAP;

        case (layer)
            LAYER_TEXT: rgb_nx = font_bit ? TEXT_FG : TEXT_BG;
            LAYER_CHAR: rgb_nx = char_rgb;
            LAYER_MAP:  rgb_nx = map_rgb;
            default:    rgb_nx = PIXEL_WIDTH'(COLOR_WHITE);
        endcase
        if (!von1)
            rgb_nx = PIXEL_WIDTH'(COLOR_BLACK);
    end

endmodule

// File: tb/tb_layered_pixel_gen.sv
// Randomised bench for layered_pixel_gen: sparse raster scan checked against a
// per-pixel reference model built from screen coordinates and frame snapshots.
module tb_layered_pixel_gen;

    localparam int SEQ_NUM    = 34;
    localparam int SEQ_DIGITS = 4;
    localparam int FW         = 8;
    localparam int ROW_H      = 11;
    localparam int DW         = SEQ_NUM * SEQ_DIGITS * 4;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        video_on = 1'b0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic [9:0]  x = '0, y = '0, char_x = '0, char_y = '0;
    logic [DW-1:0] seq_digits = '0;
    logic [9:0]  map_x, map_y, char_x_rom, char_y_rom;
    logic        map_on, char_on;
    logic [11:0] map_rgb, char_rgb, rgb;
    logic        hsync_out, vsync_out, frame_start;

    layered_pixel_gen dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .x          (x),
        .y          (y),
        .char_x     (char_x),
        .char_y     (char_y),
        .seq_digits (seq_digits),
        .map_x      (map_x),
        .map_y      (map_y),
        .char_x_rom (char_x_rom),
        .char_y_rom (char_y_rom),
        .map_on     (map_on),
        .char_on    (char_on),
        .map_rgb    (map_rgb),
        .char_rgb   (char_rgb),
        .rgb        (rgb),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .frame_start(frame_start)
    );

    always #5 sys_clk = ~sys_clk;

    logic [63:0] font_tab [16] = '{
        64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
        64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C607C6666663C00, 64'h7E060C1830303000,
        64'h3C66663C66663C00, 64'h3C66663E060C3800, 64'h183C66667E666600, 64'h7C66667C66667C00,
        64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607C60607E00, 64'h7E60607C60606000
    };

    // ROM contents seen by the DUT; data follows the registered stage-1 addresses.
    function automatic logic [11:0] mrom(input logic [9:0] a, input logic [9:0] b);
        return {a[3:0] ^ b[7:4], b[3:0], a[7:4] | 4'h1};
    endfunction

    function automatic logic [11:0] crom(input logic [9:0] a, input logic [9:0] b);
        if ((a[3:0] ^ b[3:0]) == 4'h5)
            return 12'hF0F;
        return {a[4:1], b[3:0] ^ 4'h3, 4'h8};
    endfunction

    assign map_rgb  = mrom(map_x, map_y);
    assign char_rgb = crom(char_x_rom, char_y_rom);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (x=%0d y=%0d t=%0t)", tag, act, exp, x, y, $time);
        end
    endtask

    // Reference model state
    logic [DW-1:0] frame_digits = '0;
    bit            text_valid = 1'b0;
    int            m_prev_x = 0;
    int            cur_cx = 0, cur_cy = 0;
    bit            pend_v = 1'b0;
    logic [11:0]   pend_rgb = '0;
    logic [1:0]    pend_sync = '0;
    bit            force_sync_hi = 1'b0;

    function automatic bit char_hit(input int px, input int py);
        return px >= cur_cx && px < cur_cx + 32 && py >= cur_cy && py < cur_cy + 32;
    endfunction

    function automatic bit map_hit(input int px, input int py);
        return px >= 270 && px < 370 && py >= 50 && py < 150;
    endfunction

    function automatic logic [11:0] exp_pixel(input int px, input int py, input bit von);
        int row, line;
        logic [3:0] code;
        logic [63:0] g;
        logic [11:0] c;
        row  = py / ROW_H;
        line = py % ROW_H;
        if (!von)
            return 12'h000;
        if (text_valid && row < SEQ_NUM && line < FW && px < SEQ_DIGITS * FW) begin
            code = frame_digits[(row * SEQ_DIGITS + px / FW) * 4 +: 4];
            g    = font_tab[code];
            return g[63 - (line * 8 + px % 8)] ? 12'h000 : 12'hFFF;
        end
        if (char_hit(px, py)) begin
            c = crom(10'(px - cur_cx), 10'(py - cur_cy));
`ifdef CHAR_TRANSPARENCY_EN
            if (c != 12'hF0F)
                return c;
`else
            return c;
`endif
        end
        if (map_hit(px, py))
            return mrom(10'(px - 270), 10'(py - 50));
        return 12'hFFF;
    endfunction

    task automatic drive(input int px, input int py, input bit von);
        bit ls, fs, hs, vs;
        logic [11:0] e;
        @(negedge sys_clk);
        hs = force_sync_hi ? 1'b1 : 1'($urandom);
        vs = force_sync_hi ? 1'b1 : 1'($urandom);
        x = 10'(px); y = 10'(py); video_on = von; hsync_in = hs; vsync_in = vs;
        ls = (px == 0) && (m_prev_x != 0);
        fs = ls && (py == 0);
        m_prev_x = px;
        if (fs) begin
            frame_digits = seq_digits;
            text_valid   = 1'b1;
        end
        e = exp_pixel(px, py, von);
        @(posedge sys_clk);
        #1;
        check_val("frame_start", 32'(frame_start), 32'(fs));
        check_val("char_on", 32'(char_on), 32'(char_hit(px, py)));
        check_val("map_on", 32'(map_on), 32'(map_hit(px, py)));
        if (pend_v) begin
            check_val("rgb", 32'(rgb), 32'(pend_rgb));
            check_val("sync", 32'({hsync_out, vsync_out}), 32'(pend_sync));
        end
        pend_v = 1'b1; pend_rgb = e; pend_sync = {hs, vs};
    endtask

    task automatic run_line(input int py);
        int xs[$];
        int v;
        xs.push_back(0);
        if (py < SEQ_NUM * ROW_H + 6) begin
            for (int i = 0; i < 6; i++) xs.push_back(int'($urandom_range(39, 1)));
            xs.push_back(31);
            xs.push_back(32);
        end
        xs.push_back(269); xs.push_back(270); xs.push_back(369); xs.push_back(370);
        for (int k = -1; k <= 32; k += 1) begin
            if (k == -1 || k == 0 || k == 31 || k == 32) begin
                v = cur_cx + k;
                if (v >= 1 && v <= 1023) xs.push_back(v);
            end
        end
        for (int i = 0; i < 3; i++) xs.push_back(int'($urandom_range(1023, 1)));
        foreach (xs[i]) drive(xs[i], py, ($urandom % 8) != 0);
        if (py < SEQ_NUM * ROW_H)
            drive(int'($urandom_range(31, 1)), py, 1'b0);
        drive(799, py, 1'b1);
    endtask

    task automatic mid_reset(input int py);
        force_sync_hi = 1'b1;
        drive(40, py, 1'b1);
        drive(41, py, 1'b1);
        force_sync_hi = 1'b0;
        #2 sys_rst_n = 1'b0;
        #1;
        check_val("rst_rgb", 32'(rgb), 32'h0);
        check_val("rst_sync", 32'({hsync_out, vsync_out}), 32'h0);
        check_val("rst_frame_start", 32'(frame_start), 32'h0);
        check_val("rst_map_x", 32'(map_x), 32'h0);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n  = 1'b1;
        pend_v     = 1'b0;
        text_valid = 1'b0;
        m_prev_x   = 0;
    endtask

    task automatic rand_digits(output logic [DW-1:0] d);
        for (int i = 0; i < SEQ_NUM * SEQ_DIGITS; i++) d[i*4 +: 4] = 4'($urandom);
    endtask

    task automatic run_frame(input int reset_y, input int change_y, input logic [DW-1:0] new_digits);
        for (int py = 0; py < 525; py++) begin
            if (py == change_y) seq_digits = new_digits;
            run_line(py);
            if (py == reset_y) mid_reset(py);
        end
    endtask

    logic [DW-1:0] d0, d1, d2;

    initial begin
        rand_digits(d0);
        d0[15:0] = {4'hF, 4'hA, 4'h2, 4'h1};
        rand_digits(d1);
        rand_digits(d2);
        repeat (3) @(posedge sys_clk);
        #1;
        check_val("reset_rgb", 32'(rgb), 32'h0);
        check_val("reset_sync", 32'({hsync_out, vsync_out}), 32'h0);
        check_val("reset_frame_start", 32'(frame_start), 32'h0);
        check_val("reset_on", 32'({map_on, char_on}), 32'h0);
        check_val("reset_addr", 32'({map_x, map_y, char_x_rom}), 32'h0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Before any frame start the text layer must stay off.
        cur_cx = 300; cur_cy = 60;
        char_x = 10'(cur_cx); char_y = 10'(cur_cy);
        seq_digits = d0;
        for (int py = 0; py < 12; py++) run_line(py);
        drive(799, 524, 1'b1);

        // Frame A: row 0 = 1,2,A,F; sprite over the map; reset mid-frame.
        run_frame(150, -1, d0);

        // Frame B: sprite at the right edge wrap case; digits change at y=200.
        cur_cx = 1010; cur_cy = 100;
        char_x = 10'(cur_cx); char_y = 10'(cur_cy);
        run_frame(-1, 200, d1);

        // Frame C: new digits visible; sprite somewhere random.
        cur_cx = int'($urandom_range(1000, 0)); cur_cy = int'($urandom_range(480, 0));
        char_x = 10'(cur_cx); char_y = 10'(cur_cy);
        run_frame(-1, 300, d2);

        drive(799, 0, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
